alu: RTL and testbench
======================

Name: alu

Overview:
- Single-issue integer execute unit for the out-of-order RV32 core. Three identical copies sit behind dispatch/issue as functional units FU0, FU1 and FU2; FU2 is dedicated to LW/SW.
- Each cycle it takes one fired reservation-station entry (opcode, func3, func7, two 32-bit operands, destination physical register) and returns a registered result tagged with that destination.

Parameters:
- XLEN, 32, operand and result width.
- PREG_W, 6, physical register tag width (64 physical registers).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  issue strobe; operands are valid this cycle.
- opcode_i  in  7  RV32 opcode field.
- func3_i  in  3  RV32 funct3.
- func7_i  in  7  RV32 funct7.
- src1_i  in  XLEN  operand 1 (rs1 physical register value).
- src2_i  in  XLEN  operand 2 (rs2 value, or the 12-bit I/S immediate zero-extended into bits [11:0]).
- dest_i  in  PREG_W  destination physical register tag.
- result_o  out  XLEN  computed result.
- result_dest_o  out  PREG_W  destination tag registered with the result.
- result_valid_o  out  1  result and tag are valid this cycle.

Behaviour:
- Latency and throughput:
  - Latency is exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
  - One operation is accepted per cycle; there is no stall and no backpressure.
- Reset: while rst=1 at a clock edge, result_o=0, result_dest_o=0 and result_valid_o=0. Reset takes priority over valid_i.
- Idle cycles: when valid_i=0, result_valid_o=0 on the next cycle. result_o and result_dest_o hold their previous values.
- Immediate handling: imm = sign-extend(src2_i[11:0]) for opcodes 0010011, 0000011 and 0100011. Dispatch zero-extends the immediate, so sign extension is done here.
- Opcode 0010011 (I-type):
  - func3 000: ADDI, src1 + imm.
  - func3 111: ANDI, src1 & imm.
- Opcode 0110011 (R-type):
  - func3 000, func7 0000000: ADD, src1 + src2.
  - func3 000, func7 0100000: SUB, src1 - src2.
  - func3 100: XOR, src1 ^ src2.
  - func3 101, func7 0100000: SRA, arithmetic right shift of src1 by src2[4:0].
- Opcodes 0000011 (LW) and 0100011 (SW): effective address, src1 + imm.
- All arithmetic is modulo 2^32; carries and overflow are discarded.
- Any other opcode/func3/func7 combination:
  - result_o=0.
  - result_valid_o still follows valid_i, so the ROB entry can still complete.
- result_dest_o is always the registered dest_i, including for stores; the ROB ignores the tag for stores.
- The datapath is a combinational decode plus a single output register stage; there is no other internal state.

Decomposition:
- Shared package (existing core package) holds:
  - opcode constants OP_IMM=7'b0010011, OP_REG=7'b0110011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011;
  - funct3 constants F3_ADD=000, F3_XOR=100, F3_SR=101, F3_AND=111;
  - funct7 constants F7_BASE=0000000, F7_ALT=0100000;
  - the XLEN and PREG_W constants.
- No sub-module is needed. The decode/compute is one combinational block feeding the output register.

Test Plan:
- Reset: hold rst=1 for 2 cycles with valid_i=1 -> result_o=0, result_dest_o=0, result_valid_o=0. Release rst -> first valid issue returns one cycle later.
- ADDI with negative immediate: opcode 0010011, func3 000, src1=0x10, src2=0x00000FFF, dest=5 -> next cycle result_o=0x0000000F, result_dest_o=5, result_valid_o=1.
- R-type back-to-back, one per cycle:
  - ADD 7+8 -> 0x0000000F.
  - SUB 5-7 -> 0xFFFFFFFE.
  - XOR 0xF0F0F0F0^0xFFFF0000 -> 0x0F0FF0F0.
  - Each result arrives exactly one cycle after issue, with its own dest tag.
- Logic and shift:
  - ANDI src1=0xFFFF1234, imm=0x0FF -> 0x00000034.
  - SRA src1=0x80000000, src2=0x24 (shift 4) -> 0xF8000000.
- Address generation:
  - LW src1=0x1000, src2=0x004 -> 0x1004.
  - SW src1=0x1000, src2=0xFFC -> 0x0FFC.
- Unsupported operation and idle:
  - opcode 1111111 with valid_i=1 -> result_o=0, result_valid_o=1.
  - Following cycle with valid_i=0 -> result_valid_o=0 and result_o unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared core constants for the integer execute units: widths, opcode and
// funct fields, plus the I/S immediate sign-extension helper.
package alu_pkg;

    localparam int XLEN   = 32;
    localparam int PREG_W = 6;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Dispatch delivers the 12-bit immediate zero-extended; restore its sign.
    function automatic logic [XLEN-1:0] sext_imm12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_if.sv
// Issue/result bundle between a reservation station and one ALU unit.
// valid_i qualifies the issue fields for one cycle; result_valid_o qualifies
// the result fields for one cycle. There is no ready: the unit always accepts.
interface alu_if;
    import alu_pkg::*;

    logic              valid_i;
    logic [6:0]        opcode_i;
    logic [2:0]        func3_i;
    logic [6:0]        func7_i;
    logic [XLEN-1:0]   src1_i;
    logic [XLEN-1:0]   src2_i;
    logic [PREG_W-1:0] dest_i;
    logic [XLEN-1:0]   result_o;
    logic [PREG_W-1:0] result_dest_o;
    logic              result_valid_o;

    modport master (
        output valid_i, opcode_i, func3_i, func7_i, src1_i, src2_i, dest_i,
        input  result_o, result_dest_o, result_valid_o
    );

    modport slave (
        input  valid_i, opcode_i, func3_i, func7_i, src1_i, src2_i, dest_i,
        output result_o, result_dest_o, result_valid_o
    );

endinterface

// File: rtl/alu.sv
// Single-cycle integer execute unit: combinational decode/compute feeding one
// output register stage that carries the result and its destination tag.
module alu
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    alu_if.slave bus
);

    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   result_d;
    logic [XLEN-1:0]   result_q;
    logic [PREG_W-1:0] dest_q;
    logic              valid_q;

    assign imm = sext_imm12(bus.src2_i[11:0]);

    always_comb begin
        result_d = '0;
        unique case (bus.opcode_i)
            OP_IMM: begin
                if (bus.func3_i == F3_ADD) begin
                    result_d = bus.src1_i + imm;
                end else if (bus.func3_i == F3_AND) begin
                    result_d = bus.src1_i & imm;
                end
            end
            OP_REG: begin
                if (bus.func3_i == F3_ADD && bus.func7_i == F7_BASE) begin
                    result_d = bus.src1_i + bus.src2_i;
                end else if (bus.func3_i == F3_ADD && bus.func7_i == F7_ALT) begin
                    result_d = bus.src1_i - bus.src2_i;
                end else if (bus.func3_i == F3_XOR) begin
                    result_d = bus.src1_i ^ bus.src2_i;
                end else if (bus.func3_i == F3_SR && bus.func7_i == F7_ALT) begin
                    result_d = $unsigned($signed(bus.src1_i) >>> bus.src2_i[4:0]);
                end
            end
            // Loads and stores only need the effective address from this unit.
            OP_LOAD, OP_STORE: begin
                result_d = bus.src1_i + imm;
            end
            default: begin
                result_d = '0;
            end
        endcase
    end

    // Idle cycles drop valid but keep the last result and tag on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            dest_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= bus.valid_i;
            if (bus.valid_i) begin
                result_q <= result_d;
                dest_q   <= bus.dest_i;
            end
        end
    end

    assign bus.result_o       = result_q;
    assign bus.result_dest_o  = dest_q;
    assign bus.result_valid_o = valid_q;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vector table, multi-cycle reset/idle sequences and
// random issue checked against a plain-arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    logic clk;
    logic rst;
    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0]   exp_q[$];
    logic [PREG_W-1:0] exp_dest_q[$];
    logic [XLEN-1:0]   held_res;
    logic [PREG_W-1:0] held_dest;

    typedef struct {
        logic [6:0]        op;
        logic [2:0]        f3;
        logic [6:0]        f7;
        logic [XLEN-1:0]   s1;
        logic [XLEN-1:0]   s2;
        logic [PREG_W-1:0] dest;
        logic [XLEN-1:0]   exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: RV32 semantics written with integer arithmetic.
    function automatic logic [XLEN-1:0] model(input logic [6:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        longint immv;
        longint sa;
        logic [63:0] wide;
        immv = longint'(b[11:0]);
        if (immv >= 2048) immv = immv - 4096;
        sa = longint'($signed(a));
        if (op == 7'b0010011 && f3 == 3'b000) return XLEN'(sa + immv);
        if (op == 7'b0010011 && f3 == 3'b111) return a & XLEN'(immv);
        if (op == 7'b0000011 || op == 7'b0100011) return XLEN'(sa + immv);
        if (op == 7'b0110011) begin
            if (f3 == 3'b000 && f7 == 7'd0)  return XLEN'(longint'(a) + longint'(b));
            if (f3 == 3'b000 && f7 == 7'd32) return XLEN'(longint'(a) - longint'(b));
            if (f3 == 3'b100)                return a ^ b;
            if (f3 == 3'b101 && f7 == 7'd32) begin
                wide = 64'(sa);
                wide = wide >> int'(b[4:0]);
                return wide[31:0];
            end
        end
        return '0;
    endfunction

    // Drive one cycle of issue, cross the edge, then compare one cycle later.
    task automatic step(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [XLEN-1:0] s1,
                        input logic [XLEN-1:0] s2, input logic [PREG_W-1:0] dest,
                        input logic [XLEN-1:0] expv, input string name);
        logic [XLEN-1:0]   e;
        logic [PREG_W-1:0] ed;
        bus.valid_i  = v;
        bus.opcode_i = op;
        bus.func3_i  = f3;
        bus.func7_i  = f7;
        bus.src1_i   = s1;
        bus.src2_i   = s2;
        bus.dest_i   = dest;
        if (v) begin
            exp_q.push_back(expv);
            exp_dest_q.push_back(dest);
        end
        @(posedge clk);
        #1;
        if (v) begin
            e  = exp_q.pop_front();
            ed = exp_dest_q.pop_front();
            check({name, "_valid"}, XLEN'(bus.result_valid_o), XLEN'(1));
            check({name, "_result"}, bus.result_o, e);
            check({name, "_dest"}, XLEN'(bus.result_dest_o), XLEN'(ed));
            held_res  = e;
            held_dest = ed;
        end else begin
            check({name, "_idle_valid"}, XLEN'(bus.result_valid_o), XLEN'(0));
            check({name, "_idle_hold"}, bus.result_o, held_res);
            check({name, "_idle_dest"}, XLEN'(bus.result_dest_o), XLEN'(held_dest));
        end
    endtask

    task automatic reset_cycle(input string name);
        rst = 1'b1;
        bus.valid_i  = 1'b1;
        bus.opcode_i = OP_REG;
        bus.func3_i  = F3_ADD;
        bus.func7_i  = F7_BASE;
        bus.src1_i   = 32'h1234_5678;
        bus.src2_i   = 32'h1111_1111;
        bus.dest_i   = 6'd63;
        @(posedge clk);
        #1;
        check({name, "_valid"}, XLEN'(bus.result_valid_o), XLEN'(0));
        check({name, "_result"}, bus.result_o, 32'h0);
        check({name, "_dest"}, XLEN'(bus.result_dest_o), XLEN'(0));
        held_res  = '0;
        held_dest = '0;
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0]        op;
        logic [2:0]        f3;
        logic [6:0]        f7;
        logic [XLEN-1:0]   s1;
        logic [XLEN-1:0]   s2;
        logic [PREG_W-1:0] d;
        logic [6:0] op_pool[5];
        logic [2:0] f3_pool[4];

        op_pool = '{OP_IMM, OP_REG, OP_LOAD, OP_STORE, 7'b1111111};
        f3_pool = '{F3_ADD, F3_XOR, F3_SR, F3_AND};

        vecs[0] = '{OP_REG,   F3_ADD, F7_BASE, 32'd7,         32'd8,         6'd1,  32'h0000_000F};
        vecs[1] = '{OP_REG,   F3_ADD, F7_ALT,  32'd5,         32'd7,         6'd2,  32'hFFFF_FFFE};
        vecs[2] = '{OP_REG,   F3_XOR, F7_BASE, 32'hF0F0_F0F0, 32'hFFFF_0000, 6'd3,  32'h0F0F_F0F0};
        vecs[3] = '{OP_IMM,   F3_AND, F7_BASE, 32'hFFFF_1234, 32'h0000_00FF, 6'd4,  32'h0000_0034};
        vecs[4] = '{OP_REG,   F3_SR,  F7_ALT,  32'h8000_0000, 32'h0000_0024, 6'd6,  32'hF800_0000};
        vecs[5] = '{OP_LOAD,  3'b010, F7_BASE, 32'h0000_1000, 32'h0000_0004, 6'd7,  32'h0000_1004};
        vecs[6] = '{OP_STORE, 3'b010, F7_BASE, 32'h0000_1000, 32'h0000_0FFC, 6'd8,  32'h0000_0FFC};
        vecs[7] = '{OP_REG,   F3_SR,  F7_BASE, 32'h8000_0000, 32'h0000_0004, 6'd9,  32'h0000_0000};
        vecs[8] = '{OP_IMM,   F3_ADD, F7_BASE, 32'hFFFF_FFFF, 32'h0000_0001, 6'd10, 32'h0000_0000};
        vecs[9] = '{7'b1111111, F3_ADD, F7_BASE, 32'hDEAD_BEEF, 32'h1,       6'd11, 32'h0000_0000};

        rst = 1'b1;
        held_res  = '0;
        held_dest = '0;

        reset_cycle("reset0");
        rst = 1'b1;
        reset_cycle("reset1");

        step(1'b1, OP_IMM, F3_ADD, F7_BASE, 32'h10, 32'h0000_0FFF, 6'd5, 32'h0000_000F, "addi_neg");

        for (int i = 0; i < 10; i++) begin
            step(1'b1, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].s1, vecs[i].s2,
                 vecs[i].dest, vecs[i].exp, $sformatf("vec%0d", i));
        end

        step(1'b0, 7'b1111111, F3_ADD, F7_BASE, 32'h0, 32'h0, 6'd0, 32'h0, "idle_after_bad");
        step(1'b1, OP_REG, F3_ADD, F7_BASE, 32'h0000_0100, 32'h0000_0023, 6'd42, 32'h0000_0123, "add_then_idle");
        step(1'b0, OP_REG, F3_XOR, F7_BASE, 32'hFFFF_FFFF, 32'h1, 6'd13, 32'h0, "idle_hold0");
        step(1'b0, OP_IMM, F3_AND, F7_BASE, 32'h5555_5555, 32'h7, 6'd14, 32'h0, "idle_hold1");

        for (int i = 0; i < 300; i++) begin
            op = op_pool[$urandom_range(0, 4)];
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : f3_pool[$urandom_range(0, 3)];
            case ($urandom_range(0, 2))
                0: f7 = F7_BASE;
                1: f7 = F7_ALT;
                default: f7 = 7'($urandom);
            endcase
            s1 = $urandom;
            s2 = ($urandom_range(0, 1) == 0) ? XLEN'($urandom_range(0, 4095)) : $urandom;
            d  = PREG_W'($urandom);
            step(($urandom_range(0, 4) != 0), op, f3, f7, s1, s2, d,
                 model(op, f3, f7, s1, s2), "rand");
        end

        reset_cycle("reset_mid");
        step(1'b0, OP_REG, F3_ADD, F7_BASE, 32'h0, 32'h0, 6'd0, 32'h0, "post_reset_idle");
        step(1'b1, OP_REG, F3_ADD, F7_ALT, 32'h0, 32'h1, 6'd63, 32'hFFFF_FFFF, "post_reset_sub");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
